// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
//
// Instructions arrive tagged with a 1-bit epoch. Any instruction whose epoch
// differs from the local epoch is accepted and then discarded, and it is
// counted in a saturating drop counter. A redirect flushes every held entry
// and toggles the local epoch, in lockstep with the fetch stage's global epoch.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready. in_ready and
// dec_valid depend on registered state only, never on the partner's signal.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch-side handshake; in_pc, in_inst, in_epoch payload
//   redirect_valid        flush the queue and toggle the local epoch
//   dec_valid/dec_ready   decode-side handshake (show-ahead head entry)
//   dec_pc/dec_inst/dec_epoch  head entry payload, zero when the queue is empty
//   count                 current occupancy (0..DEPTH)
//   drop_count            stale instructions discarded, saturating
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_inst,
   input  logic                     in_epoch,
   input  logic                     redirect_valid,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [31:0]              dec_pc,
   output logic [31:0]              dec_inst,
   output logic                     dec_epoch,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DROP_W-1:0]        drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   inst_mem  [DEPTH];
   logic          epoch_mem [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          cur_epoch;

   logic          in_fire;
   logic          deq_fire;
   logic          stale;
   logic          wr_en;
   logic          rd_en;
   logic          drop_en;

   assign in_ready  = (count != FULL);
   assign dec_valid = (count != '0);
   assign in_fire   = in_valid && in_ready;
   assign deq_fire  = dec_valid && dec_ready;
   assign stale     = (in_epoch != cur_epoch);

   // A redirect overrides every other state change in its cycle.
   assign wr_en   = in_fire && !stale && !redirect_valid;
   assign rd_en   = deq_fire && !redirect_valid;
   assign drop_en = in_fire && stale && !redirect_valid && (drop_count != '1);

   assign dec_pc    = dec_valid ? pc_mem[head]    : 32'h0;
   assign dec_inst  = dec_valid ? inst_mem[head]  : 32'h0;
   assign dec_epoch = dec_valid ? epoch_mem[head] : 1'b0;

   // Storage has no reset; an entry is only read once count says it is live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem[tail]    <= in_pc;
         inst_mem[tail]  <= in_inst;
         epoch_mem[tail] <= in_epoch;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         cur_epoch <= 1'b0;
      end else if (redirect_valid) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         cur_epoch <= ~cur_epoch;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (wr_en) tail <= tail + 1'b1;
         if (rd_en) head <= head + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       drop_count <= '0;
      else if (drop_en) drop_count <= drop_count + 1'b1;
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT signals ----------------
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        in_epoch = 1'b0;
   logic        redirect_valid = 1'b0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic        dec_epoch;
   logic [2:0]  count;
   logic [15:0] drop_count;

   fetch_queue #(.DEPTH(DEPTH), .DROP_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_epoch(in_epoch),
      .redirect_valid(redirect_valid),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_epoch(dec_epoch),
      .count(count), .drop_count(drop_count)
   );

   // ---------------- saturation DUT (DROP_W = 2) ----------------
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic        s_dec_valid;
   logic [31:0] s_dec_pc;
   logic [31:0] s_dec_inst;
   logic        s_dec_epoch;
   logic [2:0]  s_count;
   logic [1:0]  s_drop_count;

   fetch_queue #(.DEPTH(DEPTH), .DROP_W(2)) sat_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_pc(32'h0000_0700), .in_inst(32'h0), .in_epoch(1'b1),
      .redirect_valid(1'b0),
      .dec_valid(s_dec_valid), .dec_ready(1'b0),
      .dec_pc(s_dec_pc), .dec_inst(s_dec_inst), .dec_epoch(s_dec_epoch),
      .count(s_count), .drop_count(s_drop_count)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the queue is a plain SV queue of {pc, inst, epoch}.
   logic [31:0] exp_q[$];      // pc of each live entry, oldest first
   logic [31:0] exp_inst_q[$];
   logic        exp_ep_q[$];
   logic        m_epoch;
   logic [15:0] m_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete(); exp_inst_q.delete(); exp_ep_q.delete();
         m_epoch = 1'b0;
         m_drop  = '0;
      end else if (redirect_valid) begin
         exp_q.delete(); exp_inst_q.delete(); exp_ep_q.delete();
         m_epoch = ~m_epoch;
      end else begin
         bit take_in, take_out;
         take_out = (exp_q.size() != 0) && dec_ready;
         take_in  = in_valid && (exp_q.size() != DEPTH);
         if (take_out) begin
            void'(exp_q.pop_front());
            void'(exp_inst_q.pop_front());
            void'(exp_ep_q.pop_front());
         end
         if (take_in) begin
            if (in_epoch != m_epoch) begin
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else begin
               exp_q.push_back(in_pc);
               exp_inst_q.push_back(in_inst);
               exp_ep_q.push_back(in_epoch);
            end
         end
      end
   end

   // Compare process: outputs depend only on registered state, so the
   // negative edge is a stable sampling point.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         int n;
         n = exp_q.size();
         check("in_ready",   {31'd0, in_ready},  {31'd0, n != DEPTH});
         check("dec_valid",  {31'd0, dec_valid}, {31'd0, n != 0});
         check("count",      {29'd0, count},     n);
         check("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
         check("dec_pc",     dec_pc,   (n != 0) ? exp_q[0] : 32'h0);
         check("dec_inst",   dec_inst, (n != 0) ? exp_inst_q[0] : 32'h0);
         check("dec_epoch",  {31'd0, dec_epoch}, {31'd0, (n != 0) ? exp_ep_q[0] : 1'b0});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [31:0] pc, input logic ep,
                        input logic rdy, input logic rd);
      in_valid       = v;
      in_pc          = pc;
      in_inst        = ~pc ^ 32'h1357_9BDF;
      in_epoch       = ep;
      dec_ready      = rdy;
      redirect_valid = rd;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check("rst_dec_valid", {31'd0, dec_valid}, 0);
      check("rst_in_ready",  {31'd0, in_ready}, 1);
      check("rst_count",     {29'd0, count}, 0);
      check("rst_dec_pc",    dec_pc, 0);
      check("rst_dec_inst",  dec_inst, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      idle();

      // Fill / drain.
      for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
      check("fill_count",    {29'd0, count}, 4);
      check("fill_in_ready", {31'd0, in_ready}, 0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", dec_pc, 32'(i * 4));
         drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
      check("drain_valid", {31'd0, dec_valid}, 0);
      check("drain_count", {29'd0, count}, 0);

      // Simultaneous enqueue/dequeue at occupancy 2.
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("sim_count", {29'd0, count}, 2);
         check("sim_pc", dec_pc, 32'h10 + 32'(i * 4));
         drive(1'b1, 32'h18 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      end
      check("sim_count_end", {29'd0, count}, 2);
      drain(2);

      // Stale drop.
      check("stale_ready0", {31'd0, in_ready}, 1);
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      check("stale_ready1", {31'd0, in_ready}, 1);
      drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
      check("stale_drop",  {16'd0, drop_count}, 1);
      check("stale_count", {29'd0, count}, 1);
      check("stale_pc",    dec_pc, 32'h104);
      drain(1);

      // Redirect flush.
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      check("rd_pre_count", {29'd0, count}, 3);
      drive(1'b1, 32'h30C, 1'b0, 1'b1, 1'b1);
      check("rd_count", {29'd0, count}, 0);
      check("rd_valid", {31'd0, dec_valid}, 0);
      check("rd_drop",  {16'd0, drop_count}, 1);
      drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
      check("rd_old_epoch_drop", {16'd0, drop_count}, 2);
      check("rd_old_epoch_cnt",  {29'd0, count}, 0);
      drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
      check("rd_new_valid", {31'd0, dec_valid}, 1);
      check("rd_new_pc",    dec_pc, 32'h200);
      check("rd_new_epoch", {31'd0, dec_epoch}, 1);
      drain(1);

      // Full with dequeue: epoch is now 1.
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h500 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      check("full_ready", {31'd0, in_ready}, 0);
      drive(1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
      check("full_deq_count", {29'd0, count}, 3);
      check("full_deq_ready", {31'd0, in_ready}, 1);
      check("full_deq_pc",    dec_pc, 32'h504);
      drain(3);
      check("full_no_take", {29'd0, count}, 0);

      // Reset mid-operation with count=3, drop_count=5.
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h900 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      check("pre_rst_count", {29'd0, count}, 3);
      check("pre_rst_drop",  {16'd0, drop_count}, 5);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dec_valid", {31'd0, dec_valid}, 0);
      check("arst_in_ready",  {31'd0, in_ready}, 1);
      check("arst_count",     {29'd0, count}, 0);
      check("arst_drop",      {16'd0, drop_count}, 0);
      check("arst_dec_pc",    dec_pc, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      idle();

      // Saturation on the DROP_W=2 instance: every push is stale (epoch 1 vs 0).
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1'b1;
         @(negedge clk);
         check("sat_drop", {30'd0, s_drop_count}, (i < 3) ? i + 1 : 3);
         check("sat_count", {29'd0, s_count}, 0);
      end
      s_in_valid = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic ep;
         ep = ($urandom_range(0, 9) < 8) ? m_epoch : ~m_epoch;
         drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ep,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
